// File: rtl/pe_pkg.sv
// -----------------------------------------------------------------------------
// pe_pkg
// Shared definitions for the systolic PE: mode encodings, default bus and
// accumulator widths, the product word type, and the arithmetic helpers used
// by the accumulate lanes (saturating add and modular wrap to a given width).
// -----------------------------------------------------------------------------
package pe_pkg;

    localparam logic MODE_88 = 1'b0;   // 2 lanes, 8-bit act x 8-bit weight
    localparam logic MODE_84 = 1'b1;   // 4 lanes, 8-bit act x 4-bit weight

    localparam int ACT_W   = 16;
    localparam int WGT_W   = 8;
    localparam int ACC88_W = 20;
    localparam int ACC84_W = 14;
    localparam int OUT_W   = 56;
    localparam int PROD_W  = 16;       // widest product; 12-bit products are sign-extended

    typedef logic signed [PROD_W-1:0] prod_t;

    // Sign-extend the low w bits of x: two's-complement wrap modulo 2^w.
    function automatic logic signed [31:0] wrap_to(input logic signed [31:0] x,
                                                   input int w);
        logic signed [31:0] r;
        r = x <<< (32 - w);
        return r >>> (32 - w);
    endfunction

    // a + b clamped to the signed range of a w-bit word. Operands are small
    // enough that the 32-bit sum itself never overflows.
    function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                   input logic signed [31:0] b,
                                                   input int w);
        logic signed [31:0] s;
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        s  = a + b;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -hi - 32'sd1;
        if (s > hi)      return hi;
        else if (s < lo) return lo;
        else             return s;
    endfunction

endpackage

// File: rtl/pe_mac_lane.sv
// -----------------------------------------------------------------------------
// pe_mac_lane
// One signed accumulate lane (stage 2 of the PE MAC). A first beat replaces
// the accumulator with the incoming product; other beats add to it. The
// result is wrapped or clamped to ACC_W bits, or to NARROW_W bits when
// narrow_i is set (8x4 mode), in which case the stored value is kept
// sign-extended so later adds stay exact.
// Ports:
//   clk, reset    clock, synchronous active-high reset
//   en_i          global advance; 0 holds the accumulator
//   valid_i       product beat valid
//   first_i       beat starts a frame (clear-and-load)
//   narrow_i      accumulate at NARROW_W instead of ACC_W
//   p_i           signed product
//   acc_d_o       next accumulator value (used for same-edge capture)
// -----------------------------------------------------------------------------
module pe_mac_lane
    import pe_pkg::*;
#(
    parameter int IN_W     = PROD_W,
    parameter int ACC_W    = ACC88_W,
    parameter int NARROW_W = ACC84_W,
    parameter bit SAT      = 1'b0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en_i,
    input  logic                    valid_i,
    input  logic                    first_i,
    input  logic                    narrow_i,
    input  logic signed [IN_W-1:0]  p_i,
    output logic signed [ACC_W-1:0] acc_d_o
);

    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_d;
    logic signed [31:0]      base;
    logic signed [31:0]      sum;
    int                      lane_w;
    logic                    unused_sum_hi;

    // NOTE: every variable gets a default at the top of always_comb, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        lane_w = narrow_i ? NARROW_W : ACC_W;
        base   = first_i ? 32'sd0 : 32'(acc_q);
        if (SAT) sum = sat_add(base, 32'(p_i), lane_w);
        else     sum = wrap_to(base + 32'(p_i), lane_w);
        acc_d = acc_q;
        if (en_i && valid_i) acc_d = sum[ACC_W-1:0];
    end

    // Upper bits only mirror the sign after wrap/clamp.
    assign unused_sum_hi = ^sum[31:ACC_W];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (reset) acc_q <= '0;
        else       acc_q <= acc_d;
    end

    assign acc_d_o = acc_d;

endmodule

// File: rtl/pe_acc_drain.sv
// -----------------------------------------------------------------------------
// pe_acc_drain
// Systolic PE: forwards weights right and activations down with one cycle of
// latency, runs a 2-stage signed MAC over a first/last delimited frame, and
// hands finished results to a vertical drain chain.
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   en                            global advance (0 freezes all state)
//   mode                          0 = 8x8 (2 lanes), 1 = 8x4 (4 lanes); taken on first
//   valid_in/first_in/last_in     beat qualifiers travelling with left
//   left, up                      weights {w1,w0} or w; activations {a1,a0}
//   right, bottom, *_out          registered forwards of the inputs above
//   shift_en, psum_in, psum_out   drain chain advance, from above, to below
//   res_valid                     result register holds an unread result
//   collide                       sticky: a capture and a shift hit the same cycle
// IS_TOP marks the first PE of a column, whose psum_in carries nothing.
// -----------------------------------------------------------------------------
module pe_acc_drain
    import pe_pkg::*;
#(
    parameter int ACT_W   = pe_pkg::ACT_W,
    parameter int WGT_W   = pe_pkg::WGT_W,
    parameter int ACC88_W = pe_pkg::ACC88_W,
    parameter int ACC84_W = pe_pkg::ACC84_W,
    parameter int OUT_W   = pe_pkg::OUT_W,
    parameter bit SAT     = 1'b0,
    parameter bit IS_TOP  = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             mode,
    input  logic             valid_in,
    input  logic             first_in,
    input  logic             last_in,
    input  logic [WGT_W-1:0] left,
    input  logic [ACT_W-1:0] up,
    output logic [WGT_W-1:0] right,
    output logic             valid_out,
    output logic             first_out,
    output logic             last_out,
    output logic [ACT_W-1:0] bottom,
    input  logic             shift_en,
    input  logic [OUT_W-1:0] psum_in,
    output logic [OUT_W-1:0] psum_out,
    output logic             res_valid,
    output logic             collide
);

    // ---------------- forwarding ----------------
    logic [WGT_W-1:0] right_q;
    logic [ACT_W-1:0] bottom_q;
    logic             valid_out_q, first_out_q, last_out_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            right_q     <= '0;
            bottom_q    <= '0;
            valid_out_q <= 1'b0;
            first_out_q <= 1'b0;
            last_out_q  <= 1'b0;
        end else if (en) begin
            right_q     <= left;
            bottom_q    <= up;
            valid_out_q <= valid_in;
            first_out_q <= first_in;
            last_out_q  <= last_in;
        end
    end

    assign right     = right_q;
    assign bottom    = bottom_q;
    assign valid_out = valid_out_q;
    assign first_out = first_out_q;
    assign last_out  = last_out_q;

    // ---------------- stage 1: multiply ----------------
    // A beat is taken only if it opens a frame or one is already open, so
    // the tail of a frame cut short by reset cannot produce a result.
    logic mode_q, in_frame_q;
    logic accept, eff_mode;
    logic signed [7:0] a0, a1, w8;
    logic signed [3:0] w0, w1;
    prod_t prod [4];

    logic  s1_valid_q, s1_first_q, s1_last_q, s1_mode_q;
    prod_t s1_p_q [4];

    assign accept   = en && valid_in && (first_in || in_frame_q);
    assign eff_mode = first_in ? mode : mode_q;
    assign a0 = $signed(up[7:0]);
    assign a1 = $signed(up[15:8]);
    assign w8 = $signed(left[7:0]);
    assign w0 = $signed(left[3:0]);
    assign w1 = $signed(left[7:4]);

    always_comb begin
        prod = '{default: '0};
        if (eff_mode == MODE_88) begin
            prod[0] = 16'(a0) * 16'(w8);
            prod[1] = 16'(a1) * 16'(w8);
        end else begin
            // Lane order {a1w1, a1w0, a0w1, a0w0}, lane 0 in the LSBs.
            prod[0] = 16'(12'(a0) * 12'(w0));
            prod[1] = 16'(12'(a0) * 12'(w1));
            prod[2] = 16'(12'(a1) * 12'(w0));
            prod[3] = 16'(12'(a1) * 12'(w1));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q     <= MODE_88;
            in_frame_q <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_first_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_mode_q  <= MODE_88;
        end else if (en) begin
            s1_valid_q <= accept;
            if (accept) begin
                if (first_in) mode_q <= mode;
                in_frame_q <= !last_in;
                s1_first_q <= first_in;
                s1_last_q  <= last_in;
                s1_mode_q  <= eff_mode;
            end
        end
    end

    // NOTE: product registers are left out of reset; they are only ever
    // consumed under s1_valid_q, which is reset.
    always_ff @(posedge clk) begin
        if (accept) s1_p_q <= prod;
    end

    // ---------------- stage 2: accumulate ----------------
    logic signed [ACC88_W-1:0] acc_d [4];

    for (genvar i = 0; i < 4; i++) begin : g_lane
        pe_mac_lane #(
            .IN_W    (PROD_W),
            .ACC_W   (ACC88_W),
            .NARROW_W(ACC84_W),
            .SAT     (SAT)
        ) u_lane (
            .clk     (clk),
            .reset   (reset),
            .en_i    (en),
            .valid_i (s1_valid_q),
            .first_i (s1_first_q),
            .narrow_i(s1_mode_q == MODE_84),
            .p_i     (s1_p_q[i]),
            .acc_d_o (acc_d[i])
        );
    end

    // Lanes 2/3 are read only in 8x4 mode, where their upper bits are sign copies.
    logic unused_lane_hi;
    assign unused_lane_hi = ^{acc_d[2][ACC88_W-1:ACC84_W], acc_d[3][ACC88_W-1:ACC84_W]};

    // ---------------- result register / drain ----------------
    logic             capture;
    logic [OUT_W-1:0] packed_res;
    logic [OUT_W-1:0] result_q, result_d;
    logic             res_valid_q, res_valid_d;
    logic             collide_q, collide_d;

    // Capture takes the accumulator's next value, so the result lands on the
    // same edge the last beat is accumulated.
    assign capture = en && s1_valid_q && s1_last_q;

    always_comb begin
        if (s1_mode_q == MODE_88)
            packed_res = {{(OUT_W-2*ACC88_W){1'b0}}, acc_d[1], acc_d[0]};
        else
            packed_res = {acc_d[3][ACC84_W-1:0], acc_d[2][ACC84_W-1:0],
                          acc_d[1][ACC84_W-1:0], acc_d[0][ACC84_W-1:0]};
    end

    always_comb begin
        result_d    = result_q;
        res_valid_d = res_valid_q;
        collide_d   = collide_q;
        if (capture) begin
            // Own result wins; whatever was arriving from above is lost.
            result_d    = packed_res;
            res_valid_d = 1'b1;
            if (shift_en) collide_d = 1'b1;
        end else if (en && shift_en) begin
            result_d    = psum_in;
            res_valid_d = !IS_TOP;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            result_q    <= '0;
            res_valid_q <= 1'b0;
            collide_q   <= 1'b0;
        end else begin
            result_q    <= result_d;
            res_valid_q <= res_valid_d;
            collide_q   <= collide_d;
        end
    end

    assign psum_out  = result_q;
    assign res_valid = res_valid_q;
    assign collide   = collide_q;

endmodule
